vend_key_events: RTL
====================

# vend_key_events

Input-event front end for the vending SoC. It synchronises and debounces the raw slide switches that carry the coin, Done, Confirm and Cancel inputs, and turns each debounced rising edge into a timestamped event. Events are queued in a small FIFO that the Nios CPU drains over an Avalon-MM slave, with an optional level interrupt. The block sits between the board switches and the system0 Avalon fabric, in the same position as the current debouncer-to-PIO path.

## Interface
Parameters:
- N_IN, 6, number of switch inputs. Bit order is {Cancel, Confirm, Done, coins[2:0]}.
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
- FIFO_DEPTH, 8, number of event entries. Must be a power of two, 2..16.

Ports:
- clk  in  1  system clock (CPU_CLK domain).
- rst  in  1  reset; asynchronous, active-high.
- key_in  in  N_IN  raw switch levels, asynchronous to clk.
- level_out  out  N_IN  debounced levels.
- avs_address  in  2  register select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt to the CPU.

## Operation
- **Synchroniser:** each key_in bit passes through two flops before any other logic.
- **Debounce, per bit:**
  - stable[i] holds the accepted level.
  - When the synchronised bit differs from stable[i], cnt[i] increments. When they are equal, cnt[i] clears.
  - When cnt[i] reaches DEBOUNCE_CYCLES-1 while the bits still differ, stable[i] toggles and cnt[i] clears.
  - level_out equals stable.
- **Event generation:**
  - rise[i] = stable[i] goes 0→1 in this cycle. Falling edges generate no event.
  - If any rise bit is set, exactly one entry {ts[15:0], rise[N_IN-1:0]} is pushed. Simultaneous rises share a single entry.
- **Timestamp:** ts is a 16-bit free-running counter that increments every cycle and wraps from 0xFFFF to 0x0000.
- **FIFO:**
  - Entries are in order; count runs 0..FIFO_DEPTH.
  - A push while full drops the new entry and sets the sticky ovf flag.
  - Push and pop in the same cycle while full: both occur, count is unchanged, ovf stays clear.
  - Push and pop in the same cycle while empty: the read sees empty, the push completes, count becomes 1.
  - Flush sets count to 0 and resets the pointers. A push in the same cycle as a flush is discarded.
- **Registers:**
  - Address 0, DATA (R): returns bit31=1, [21:6]=ts, [5:0]=mask, and pops the head entry. When empty it returns 0 and does not pop.
  - Address 1, STATUS (R): [4:0]=count, [8]=ovf, [9]=irq_en, [21:16]=level_out.
  - Address 2, CONTROL (W): bit0 writes irq_en; bit1=1 clears ovf; bit2=1 flushes the FIFO. Reads return {irq_en} in bit 0.
  - Address 3, TIME (R): returns the current ts in [15:0].
  - Writes to addresses 0, 1 and 3 are ignored.
  - A read and a write asserted in the same cycle: the write is applied and the read returns 0.
- **Interrupt:** irq = irq_en & (count != 0), registered.
- **Reset:**
  - Clears the synchronisers, stable, cnt, ts, FIFO pointers, count, ovf, irq_en, avs_readdata and irq to 0.
  - level_out is therefore 0 after reset. A switch held high through reset produces one event after DEBOUNCE_CYCLES.
  - Reset asserted mid-debounce or mid-read discards all state. No partial entry is retained.

## Timing
- Path from a key_in edge to the stable change: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles.
- Path from the stable rise to the FIFO entry being visible in count: 1 cycle (the push registers on the cycle after the rise).
- The ts value stored in an entry is the ts value in the cycle of the rise.
- Avalon read latency is fixed at 1 with no wait states. avs_readdata is valid on the cycle after avs_read and holds until the next read. The pop takes effect at the clk edge that samples avs_read.
- irq updates 1 cycle after count or irq_en changes.
- Back-to-back DATA reads are legal on every cycle. Each read pops exactly one entry.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=8.
- **Debounce reject:** glitch key_in[0] high for 3 cycles, then low → level_out stays 0, count stays 0.
- **Single event:** hold key_in[3] (Done) high → level_out[3]=1 six cycles after the edge. A DATA read then returns 0x80000000 | (ts<<6) | 0x08, and a following DATA read returns 0.
- **Simultaneous rises:** raise key_in[1:0] in the same cycle → exactly one entry with mask 0x03; STATUS count=1.
- **Overflow and same-cycle pop:**
  - Generate 9 distinct events with no reads → count=8, ovf=1, and the oldest 8 entries read back in order.
  - Repeat with a DATA read landing on the cycle of the 9th push → ovf=0, count=8.
- **Control:**
  - Write CONTROL=0x1 with count=2 → irq=1 one cycle later.
  - Write 0x5 → count=0, irq drops one cycle later.
  - Write 0x2 → ovf clears.
- **Reset mid-operation:** assert rst during debounce with 3 entries queued → all outputs read 0 immediately. After release, holding key_in[5] high yields one entry with mask 0x20.

Source files
------------

// File: rtl/vend_key_events.sv
// vend_key_events
// Switch-input front end for the vending SoC. Raw slide switches
// {Cancel, Confirm, Done, coins[2:0]} are synchronised, debounced, and
// every debounced rising edge is turned into a timestamped event queued in
// a small FIFO. The Nios CPU drains the FIFO over an Avalon-MM slave and can
// enable a level interrupt that is raised while the FIFO holds entries.
//
// Ports:
//   clk            system clock (CPU_CLK domain)
//   rst            asynchronous active-high reset
//   key_in         raw switch levels, asynchronous to clk
//   level_out      debounced switch levels
//   avs_address    register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 TIME
//   avs_read       read strobe (fixed latency 1, no wait states)
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, holds until the next read
//   irq            registered level interrupt: irq_en & FIFO not empty
module vend_key_events #(
    parameter int N_IN            = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   key_in,
    output logic [N_IN-1:0]   level_out,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W  = PTR_W + 1;
    localparam int ENTRY_W = 16 + N_IN;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

    // DATA word: valid flag in bit 31, timestamp above the rise mask.
    function automatic logic [31:0] pack_data(input logic [ENTRY_W-1:0] e);
        logic [31:0] w;
        w                = '0;
        w[31]            = 1'b1;
        w[N_IN +: 16]    = e[ENTRY_W-1 -: 16];
        w[N_IN-1:0]      = e[N_IN-1:0];
        return w;
    endfunction

    function automatic logic [31:0] pack_status(input logic [FCNT_W-1:0] c,
                                                input logic o,
                                                input logic ie,
                                                input logic [N_IN-1:0] lv);
        logic [31:0] w;
        w               = '0;
        w[FCNT_W-1:0]   = c;
        w[8]            = o;
        w[9]            = ie;
        w[16 +: N_IN]   = lv;
        return w;
    endfunction

    // ---- stage p0/p1: two-flop synchroniser ----
    logic [N_IN-1:0] sync_p0;
    logic [N_IN-1:0] sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= key_in;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: per-bit debounce ----
    logic [CNT_W-1:0] cnt [N_IN];
    logic [N_IN-1:0]  stable;
    logic [N_IN-1:0]  stable_d;
    logic [N_IN-1:0]  rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
            stable   <= '0;
            stable_d <= '0;
        end else begin
            stable_d <= stable;
            for (int i = 0; i < N_IN; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign level_out = stable;
    assign rise      = stable & ~stable_d;

    // Free-running timestamp; an entry captures the value of the rise cycle.
    logic [15:0] ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else     ts <= ts + 16'd1;
    end

    // ---- event FIFO ----
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [FCNT_W-1:0]  count;
    logic               ovf;
    logic               irq_en;

    logic fifo_empty, fifo_full;
    logic rd_req, wr_ctrl, flush, pop, push_req, push, drop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    // A simultaneous write wins: the read returns 0 and must not pop.
    assign rd_req     = avs_read & ~avs_write;
    assign wr_ctrl    = avs_write & (avs_address == 2'd2);
    assign flush      = wr_ctrl & avs_writedata[2];
    assign pop        = rd_req & (avs_address == 2'd0) & ~fifo_empty;
    assign push_req   = (|rise) & ~flush;
    // When full, a same-cycle pop frees the slot for the incoming entry.
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:3];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ts, rise};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + FCNT_W'(1);
                    2'b01:   count <= count - FCNT_W'(1);
                    default: count <= count;
                endcase
            end
            if (wr_ctrl) begin
                irq_en <= avs_writedata[0];
                if (avs_writedata[1]) ovf <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) ovf <= 1'b1;
            irq <= irq_en & (count != '0);
        end
    end

    // ---- Avalon read port, latency 1 ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            if (avs_write) begin
                avs_readdata <= '0;
            end else begin
                case (avs_address)
                    2'd0:    avs_readdata <= fifo_empty ? '0 : pack_data(mem[rd_ptr]);
                    2'd1:    avs_readdata <= pack_status(count, ovf, irq_en, stable);
                    2'd2:    avs_readdata <= {31'd0, irq_en};
                    default: avs_readdata <= {16'd0, ts};
                endcase
            end
        end
    end

endmodule
